// File: rtl/ioctl_upload_responder.sv
// ---------------------------------------------------------------------------
// ioctl_upload_responder
//
// Answers hps_io upload reads (ioctl_rd) for one upload slot with bytes fetched
// from a synchronous read RAM on the core side, such as an input-event log.
// While a RAM fetch is outstanding, ioctl_wait stalls the HPS. Addresses at or
// beyond DEPTH return FILL_BYTE immediately and do not touch the RAM.
//
// Optional build macro: UPLOAD_CHECKSUM_EN adds a running XOR checksum output
// (csum) over every byte handed back to the HPS during the current session.
//
// Ports
//   clk_sys       in   system clock
//   reset_n       in   asynchronous active-low reset
//   ioctl_upload  in   upload session active (level)
//   ioctl_index   in   selected upload slot
//   ioctl_rd      in   one-cycle read strobe, ioctl_addr valid with it
//   ioctl_addr    in   25-bit byte address of the request
//   ioctl_din     out  returned byte, held until the next completed request
//   ioctl_wait    out  high while a RAM fetch is outstanding
//   mem_rd        out  one-cycle RAM read strobe
//   mem_addr      out  RAM read address
//   mem_q         in   RAM data, valid RD_LAT cycles after mem_rd
//   upload_done   out  one-cycle pulse when a selected session ends
//   csum          out  XOR of returned bytes (only with UPLOAD_CHECKSUM_EN)
//   proto_err     out  sticky; a read strobe arrived while a fetch was pending
// ---------------------------------------------------------------------------
module ioctl_upload_responder #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DEPTH        = 16384,
    parameter int unsigned RD_LAT       = 2,
    parameter logic [7:0]  UPLOAD_INDEX = 8'd2,
    parameter logic [7:0]  FILL_BYTE    = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic              upload_done,
`ifdef UPLOAD_CHECKSUM_EN
    output logic [7:0]        csum,
`endif
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        FETCH = 2'd2
    } state_t;

    // Full-width bound so that large addresses never alias into the RAM.
    localparam logic [24:0] DEPTH_A = 25'(DEPTH);
    localparam logic [2:0]  LAT_C   = 3'(RD_LAT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;

    logic              sel;
    logic              in_range;
    logic              resp_en;     // a byte is handed to the HPS this cycle
    logic [7:0]        resp_byte;

    assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_range = (ioctl_addr < DEPTH_A);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            din_q      <= 8'h00;
            wait_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            wait_q     <= wait_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        perr_d     = perr_q;
        resp_en    = 1'b0;
        resp_byte  = 8'h00;

        case (state_q)
            IDLE: begin
                wait_d = 1'b0;
                cnt_d  = 3'd0;
                if (sel) begin
                    state_d = READY;
                    perr_d  = 1'b0;
                end
            end

            READY: begin
                if (!sel) begin
                    // Session end has priority over a read in the same cycle.
                    state_d = IDLE;
                    wait_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = 3'd0;
                end else if (ioctl_rd) begin
                    if (in_range) begin
                        mem_addr_d = ioctl_addr[ADDR_W-1:0];
                        mem_rd_d   = 1'b1;
                        wait_d     = 1'b1;
                        cnt_d      = LAT_C;
                        state_d    = FETCH;
                    end else begin
                        resp_en   = 1'b1;
                        resp_byte = FILL_BYTE;
                    end
                end
            end

            FETCH: begin
                if (!sel) begin
                    // Abort: the pending RAM word is simply never captured.
                    state_d = IDLE;
                    wait_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = 3'd0;
                end else begin
                    if (ioctl_rd) begin
                        perr_d = 1'b1;
                    end
                    // cnt reaches zero in the cycle mem_q carries the word
                    // requested RD_LAT cycles earlier by mem_rd.
                    if (cnt_q == 3'd0) begin
                        resp_en   = 1'b1;
                        resp_byte = mem_q;
                        wait_d    = 1'b0;
                        state_d   = READY;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                wait_d  = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase

        din_d = resp_en ? resp_byte : din_q;
    end

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       session_start;

    assign session_start = (state_q == IDLE) && sel;

    always_comb begin
        csum_d = csum_q;
        if (session_start) begin
            csum_d = 8'h00;
        end else if (resp_en) begin
            csum_d = csum_q ^ resp_byte;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign upload_done = done_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// ---------------------------------------------------------------------------
// Testbench for ioctl_upload_responder. A behavioural RAM with RD_LAT cycles of
// read latency feeds mem_q; cycles without a read put random junk on mem_q so
// a mistimed capture is visible. Build with UPLOAD_CHECKSUM_EN defined to also
// check csum.
// ---------------------------------------------------------------------------
module tb_ioctl_upload_responder;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16384;
    localparam int RD_LAT = 2;
    localparam logic [7:0] FILL = 8'hFF;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_upload = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic              ioctl_rd = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_q;
    logic              upload_done;
    logic              proto_err;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .RD_LAT      (RD_LAT),
        .UPLOAD_INDEX(8'd2),
        .FILL_BYTE   (FILL)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .upload_done (upload_done),
`ifdef UPLOAD_CHECKSUM_EN
        .csum        (csum),
`endif
        .proto_err   (proto_err)
    );

    // Behavioural RAM: mem_q carries ram[addr] exactly RD_LAT cycles after mem_rd.
    logic [7:0] ram  [DEPTH];
    logic [7:0] pipe [RD_LAT];

    always @(posedge clk_sys) begin
        pipe[0] <= mem_rd ? ram[mem_addr] : 8'($urandom);
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_q = pipe[RD_LAT-1];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_din, input logic e_wait,
                             input logic e_mrd, input logic [13:0] e_maddr, input logic e_done,
                             input logic e_perr, input logic [7:0] e_csum);
        chk({tag, ".din"},  32'(ioctl_din),   32'(e_din));
        chk({tag, ".wait"}, 32'(ioctl_wait),  32'(e_wait));
        chk({tag, ".mrd"},  32'(mem_rd),      32'(e_mrd));
        chk({tag, ".madr"}, 32'(mem_addr),    32'(e_maddr));
        chk({tag, ".done"}, 32'(upload_done), 32'(e_done));
        chk({tag, ".perr"}, 32'(proto_err),   32'(e_perr));
`ifdef UPLOAD_CHECKSUM_EN
        chk({tag, ".csum"}, 32'(csum),        32'(e_csum));
`else
        if (e_csum === 8'hxx) $display("note: csum expectation unknown in %s", tag);
`endif
    endtask

    typedef struct {
        logic        up;
        logic [7:0]  idx;
        logic        rd;
        logic [24:0] addr;
        logic [7:0]  e_din;
        logic        e_wait;
        logic        e_mrd;
        logic [13:0] e_maddr;
        logic        e_done;
        logic        e_perr;
        logic [7:0]  e_csum;
    } vec_t;

    function automatic vec_t mk(input logic up, input logic [7:0] idx, input logic rd,
                                input logic [24:0] addr, input logic e_wait, input logic e_mrd,
                                input logic [13:0] e_maddr, input logic [7:0] e_din,
                                input logic e_done, input logic e_perr, input logic [7:0] e_csum);
        vec_t v;
        v.up = up; v.idx = idx; v.rd = rd; v.addr = addr;
        v.e_wait = e_wait; v.e_mrd = e_mrd; v.e_maddr = e_maddr; v.e_din = e_din;
        v.e_done = e_done; v.e_perr = e_perr; v.e_csum = e_csum;
        return v;
    endfunction

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    initial begin
        logic saw_mrd, saw_wait;
        // reference model state for the random phase
        logic        m_sess, m_busy;
        int          m_fin;
        logic [24:0] m_paddr;
        logic [7:0]  m_din, m_csum;
        logic        m_wait, m_mrd, m_done, m_perr;
        logic [13:0] m_maddr;
        logic        sel;
        int          r;

        for (int a = 0; a < DEPTH; a++) ram[a] = 8'($urandom);
        ram[14'h10] = 8'hA5;
        ram[14'h11] = 8'h12;
        ram[14'h12] = 8'h34;

        //           up idx  rd addr          wait mrd madr    din    done perr csum
        tbl[0]  = mk(1, 2,   0, 25'h0,        0,   0,  14'h00, 8'h00, 0,   0,   8'h00);
        tbl[1]  = mk(1, 2,   1, 25'h10,       1,   1,  14'h10, 8'h00, 0,   0,   8'h00);
        tbl[2]  = mk(1, 2,   0, 25'h0,        1,   0,  14'h10, 8'h00, 0,   0,   8'h00);
        tbl[3]  = mk(1, 2,   0, 25'h0,        1,   0,  14'h10, 8'h00, 0,   0,   8'h00);
        tbl[4]  = mk(1, 2,   0, 25'h0,        0,   0,  14'h10, 8'hA5, 0,   0,   8'hA5);
        tbl[5]  = mk(1, 2,   1, 25'h4000,     0,   0,  14'h10, 8'hFF, 0,   0,   8'h5A);
        tbl[6]  = mk(1, 2,   1, 25'h1000010,  0,   0,  14'h10, 8'hFF, 0,   0,   8'hA5);
        tbl[7]  = mk(1, 2,   1, 25'h11,       1,   1,  14'h11, 8'hFF, 0,   0,   8'hA5);
        tbl[8]  = mk(1, 2,   1, 25'h12,       1,   0,  14'h11, 8'hFF, 0,   1,   8'hA5);
        tbl[9]  = mk(1, 2,   0, 25'h0,        1,   0,  14'h11, 8'hFF, 0,   1,   8'hA5);
        tbl[10] = mk(1, 2,   0, 25'h0,        0,   0,  14'h11, 8'h12, 0,   1,   8'hB7);
        tbl[11] = mk(1, 1,   0, 25'h0,        0,   0,  14'h11, 8'h12, 1,   1,   8'hB7);
        tbl[12] = mk(1, 1,   1, 25'h10,       0,   0,  14'h11, 8'h12, 0,   1,   8'hB7);
        tbl[13] = mk(1, 2,   0, 25'h0,        0,   0,  14'h11, 8'h12, 0,   0,   8'h00);
        tbl[14] = mk(1, 2,   1, 25'h12,       1,   1,  14'h12, 8'h12, 0,   0,   8'h00);
        tbl[15] = mk(1, 2,   0, 25'h0,        1,   0,  14'h12, 8'h12, 0,   0,   8'h00);
        tbl[16] = mk(0, 2,   0, 25'h0,        0,   0,  14'h12, 8'h12, 1,   0,   8'h00);
        tbl[17] = mk(0, 2,   0, 25'h0,        0,   0,  14'h12, 8'h12, 0,   0,   8'h00);
        tbl[18] = mk(1, 2,   0, 25'h0,        0,   0,  14'h12, 8'h12, 0,   0,   8'h00);
        tbl[19] = mk(1, 2,   1, 25'h11,       1,   1,  14'h11, 8'h12, 0,   0,   8'h00);
        tbl[20] = mk(1, 2,   0, 25'h0,        1,   0,  14'h11, 8'h12, 0,   0,   8'h00);
        tbl[21] = mk(1, 2,   0, 25'h0,        1,   0,  14'h11, 8'h12, 0,   0,   8'h00);
        tbl[22] = mk(1, 2,   0, 25'h0,        0,   0,  14'h11, 8'h12, 0,   0,   8'h12);
        tbl[23] = mk(1, 2,   1, 25'h12,       1,   1,  14'h12, 8'h12, 0,   0,   8'h12);
        tbl[24] = mk(1, 2,   0, 25'h0,        1,   0,  14'h12, 8'h12, 0,   0,   8'h12);
        tbl[25] = mk(1, 2,   0, 25'h0,        1,   0,  14'h12, 8'h12, 0,   0,   8'h12);
        tbl[26] = mk(1, 2,   0, 25'h0,        0,   0,  14'h12, 8'h34, 0,   0,   8'h26);
        tbl[27] = mk(1, 2,   1, 25'h4000,     0,   0,  14'h12, 8'hFF, 0,   0,   8'hD9);

        // ---- reset values, then an idle stretch with stray read strobes ----
        repeat (2) @(negedge clk_sys);
        check_out("reset", 8'h00, 0, 0, 14'h0, 0, 0, 8'h00);
        $display("reset: din=%h wait=%b mrd=%b", ioctl_din, ioctl_wait, mem_rd);
        reset_n = 1'b1;
        ioctl_index = 8'd2;
        saw_mrd = 1'b0;
        saw_wait = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ioctl_rd   = 1'($urandom_range(0, 1));
            ioctl_addr = 25'($urandom_range(0, DEPTH - 1));
            @(negedge clk_sys);
            if (mem_rd) saw_mrd = 1'b1;
            if (ioctl_wait) saw_wait = 1'b1;
        end
        ioctl_rd = 1'b0;
        chk("idle.mrd_seen", 32'(saw_mrd), 32'd0);
        chk("idle.wait_seen", 32'(saw_wait), 32'd0);
        $display("idle: 100 cycles, mem_rd seen=%b wait seen=%b", saw_mrd, saw_wait);

        // ---- directed per-cycle vectors ----
        for (int i = 0; i < NVEC; i++) begin
            ioctl_upload = tbl[i].up;
            ioctl_index  = tbl[i].idx;
            ioctl_rd     = tbl[i].rd;
            ioctl_addr   = tbl[i].addr;
            @(negedge clk_sys);
            check_out($sformatf("vec%0d", i), tbl[i].e_din, tbl[i].e_wait, tbl[i].e_mrd,
                      tbl[i].e_maddr, tbl[i].e_done, tbl[i].e_perr, tbl[i].e_csum);
            $display("vec %0d: up=%b idx=%0d rd=%b addr=%h -> din=%h wait=%b mrd=%b done=%b perr=%b",
                     i, tbl[i].up, tbl[i].idx, tbl[i].rd, tbl[i].addr, ioctl_din, ioctl_wait,
                     mem_rd, upload_done, proto_err);
        end

        // ---- asynchronous reset in the middle of a fetch ----
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h10;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("arst.pre_wait", 32'(ioctl_wait), 32'd1);
        chk("arst.pre_mrd", 32'(mem_rd), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_out("arst", 8'h00, 0, 0, 14'h0, 0, 0, 8'h00);
        $display("async reset mid-fetch: din=%h wait=%b mrd=%b madr=%h", ioctl_din, ioctl_wait,
                 mem_rd, mem_addr);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // ---- randomized traffic against a transaction-timing model ----
        m_sess = 0; m_busy = 0; m_fin = 0; m_paddr = '0;
        m_din = 8'h00; m_csum = 8'h00; m_wait = 0; m_mrd = 0; m_done = 0; m_perr = 0;
        m_maddr = 14'h0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 4) ioctl_upload = ~ioctl_upload;
            ioctl_index = ($urandom_range(0, 99) < 3) ? 8'($urandom) : 8'd2;
            ioctl_rd    = ($urandom_range(0, 99) < 30);
            r = int'($urandom_range(0, 9));
            if (r < 7)       ioctl_addr = 25'($urandom_range(0, DEPTH - 1));
            else if (r == 7) ioctl_addr = 25'(DEPTH - 1 + int'($urandom_range(0, 2)));
            else if (r == 8) ioctl_addr = 25'($urandom);
            else             ioctl_addr = 25'($urandom_range(0, 15));

            // Expected outputs after this cycle's clock edge. A request accepted
            // in cycle i is answered at the edge closing cycle i+1+RD_LAT.
            sel = ioctl_upload && (ioctl_index == 8'd2);
            m_mrd = 0;
            m_done = 0;
            if (!m_sess) begin
                m_wait = 0;
                if (sel) begin
                    m_sess = 1; m_perr = 0; m_csum = 8'h00;
                end
            end else if (!sel) begin
                m_sess = 0; m_busy = 0; m_wait = 0; m_done = 1;
            end else if (m_busy) begin
                if (ioctl_rd) m_perr = 1;
                if (i == m_fin) begin
                    m_din = ram[m_paddr[13:0]];
                    m_csum = m_csum ^ m_din;
                    m_busy = 0;
                    m_wait = 0;
                    $display("rnd %0d: read addr=%h data=%h", i, m_paddr, m_din);
                end
            end else if (ioctl_rd) begin
                if (ioctl_addr < 25'(DEPTH)) begin
                    m_busy = 1; m_fin = i + 1 + RD_LAT; m_paddr = ioctl_addr;
                    m_wait = 1; m_mrd = 1; m_maddr = ioctl_addr[13:0];
                end else begin
                    m_din = FILL;
                    m_csum = m_csum ^ FILL;
                    $display("rnd %0d: read addr=%h out of range data=%h", i, ioctl_addr, m_din);
                end
            end
            @(negedge clk_sys);
            check_out($sformatf("rnd%0d", i), m_din, m_wait, m_mrd, m_maddr, m_done, m_perr, m_csum);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
